// File: rtl/cerceve_alici_pkg.sv
// cerceve_pkg: shared FSM state type, frame constants and the even-parity helper for cerceve_alici.
package cerceve_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} durum_t;
  localparam int DATA_BITS = 3;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
  function automatic logic cift_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/cerceve_alici_if.sv
// cerceve_alici_if: serial input, output stream handshake and status pulses of cerceve_alici.
//   rx          serial line into the receiver (idles high)
//   cikis_ready consumer accepts the head word
//   gelen_sayi  head word of the receive buffer
//   cikis_valid buffer holds at least one word
//   doluluk     number of buffered words
//   parity_err / frame_err / overflow  one-cycle drop pulses
//   master: the side that drives rx and consumes words; slave: the receiver.
interface cerceve_alici_if #(parameter int FIFO_DEPTH = 4);
  logic rx;
  logic cikis_ready;
  logic [2:0] gelen_sayi;
  logic cikis_valid;
  logic [$clog2(FIFO_DEPTH):0] doluluk;
  logic parity_err;
  logic frame_err;
  logic overflow;
  modport master (
    output rx, cikis_ready,
    input gelen_sayi, cikis_valid, doluluk, parity_err, frame_err, overflow
  );
  modport slave (
    input rx, cikis_ready,
    output gelen_sayi, cikis_valid, doluluk, parity_err, frame_err, overflow
  );
endinterface

// File: rtl/cerceve_alici_fifo.sv
// kucuk_fifo: small power-of-two FIFO with occupancy count; push into a full FIFO is taken only alongside a pop.
//   clk, rst  clock and asynchronous active-high reset
//   push/wdata write request and data; pop read request (ignored when empty)
//   rdata     head word (0 while empty); full, empty, count  occupancy status
module kucuk_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + AW'(1) : wp;
      rp <= do_pop ? rp + AW'(1) : rp;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/cerceve_alici.sv
// cerceve_alici: serial frame receiver (start, 3 data bits LSB first, even parity, stop) feeding a small FIFO.
//   clk, rst  clock and asynchronous active-high reset
//   bus       cerceve_alici_if slave: rx in, cikis_ready in, gelen_sayi/cikis_valid/doluluk out,
//             parity_err/frame_err/overflow one-cycle drop pulses
module cerceve_alici
  import cerceve_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  cerceve_alici_if.slave bus
);
  localparam int HALF = BIT_CYCLES / 2;
  logic rx_m, rx_s, rx_d;
  durum_t durum, sonraki;
  logic [7:0] cnt;
  logic [1:0] bit_i;
  logic [DATA_BITS-1:0] veri;
  logic par;
  logic son, push, pop, full, empty;
  logic perr_n, ferr_n, ovf_n;
  logic perr, ferr, ovf;
  logic [DATA_BITS-1:0] rdata;
  logic [$clog2(FIFO_DEPTH):0] count;
  // START waits half a bit to land mid-bit; every later sample is one full bit apart.
  assign son = cnt == (durum == START ? 8'(HALF - 1) : 8'(BIT_CYCLES - 1));
  assign pop = ~empty & bus.cikis_ready;
  always_comb begin
    sonraki = durum;
    push = 1'b0;
    perr_n = 1'b0;
    ferr_n = 1'b0;
    ovf_n = 1'b0;
    case (durum)
      IDLE: sonraki = (rx_d & ~rx_s) ? START : IDLE;
      START: sonraki = son ? (rx_s == START_LVL ? DATA : IDLE) : START;
      DATA: sonraki = (son && bit_i == 2'(DATA_BITS - 1)) ? PARITY : DATA;
      PARITY: sonraki = son ? STOP : PARITY;
      STOP: begin
        sonraki = son ? IDLE : STOP;
        ferr_n = son & (rx_s != STOP_LVL);
        perr_n = son & ~ferr_n & (par != cift_parity(veri));
        ovf_n = son & ~ferr_n & ~perr_n & full & ~pop;
        push = son & ~ferr_n & ~perr_n & ~ovf_n;
      end
      default: sonraki = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
      durum <= IDLE;
      cnt <= '0;
      bit_i <= '0;
      veri <= '0;
      par <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      ovf <= 1'b0;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
      durum <= sonraki;
      cnt <= (durum == IDLE || son) ? '0 : cnt + 8'd1;
      bit_i <= durum == IDLE ? '0 : (durum == DATA && son) ? bit_i + 2'd1 : bit_i;
      veri <= (durum == DATA && son) ? {rx_s, veri[DATA_BITS-1:1]} : veri;
      par <= (durum == PARITY && son) ? rx_s : par;
      perr <= perr_n;
      ferr <= ferr_n;
      ovf <= ovf_n;
    end
  kucuk_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata(veri),
    .rdata(rdata),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign bus.gelen_sayi = rdata;
  assign bus.cikis_valid = ~empty;
  assign bus.doluluk = count;
  assign bus.parity_err = perr;
  assign bus.frame_err = ferr;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_cerceve_alici.sv
// tb_cerceve_alici: table-driven frames plus hand-written corner sequences, words checked through a scoreboard queue.
module tb_cerceve_alici;
  localparam int BC = 4;
  localparam int FD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cerceve_alici_if #(.FIFO_DEPTH(FD)) bus();
  cerceve_alici #(.BIT_CYCLES(BC), .FIFO_DEPTH(FD)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_pass = 0;
  int perr_n = 0, ferr_n = 0, ovf_n = 0, val_n = 0;
  logic [2:0] sb[$];
  typedef struct {
    logic [2:0] d;
    bit par_ok;
    bit stop;
    int e_perr;
    int e_ferr;
    int e_ok;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (bus.parity_err) perr_n++;
      if (bus.frame_err) ferr_n++;
      if (bus.overflow) ovf_n++;
      if (bus.cikis_valid) val_n++;
      if (bus.cikis_valid && bus.cikis_ready) begin
        if (sb.size() == 0) chk("unexpected_word", int'(bus.gelen_sayi), -1);
        else chk("sb_word", int'(bus.gelen_sayi), int'(sb.pop_front()));
      end
    end
  task automatic bit_out(input logic v);
    bus.rx = v;
    repeat (BC) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [2:0] d, input logic p, input logic s);
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(d[i]);
    bit_out(p);
    bit_out(s);
    bit_out(1'b1);
    bit_out(1'b1);
  endtask
  task automatic chk_quiet(input string nm);
    chk({nm, "_out"}, int'({bus.gelen_sayi, bus.cikis_valid, bus.doluluk}), 0);
    chk({nm, "_err"}, int'({bus.parity_err, bus.frame_err, bus.overflow}), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int p0, f0, o0, v0;
    vecs[0] = '{3'b101, 1, 1, 0, 0, 1};
    vecs[1] = '{3'b011, 0, 1, 1, 0, 0};
    vecs[2] = '{3'b110, 1, 0, 0, 1, 0};
    vecs[3] = '{3'b001, 1, 1, 0, 0, 1};
    vecs[4] = '{3'b000, 1, 1, 0, 0, 1};
    vecs[5] = '{3'b111, 1, 1, 0, 0, 1};
    vecs[6] = '{3'b010, 0, 1, 1, 0, 0};
    vecs[7] = '{3'b100, 0, 0, 0, 1, 0};
    vecs[8] = '{3'b110, 1, 1, 0, 0, 1};
    bus.rx = 1'b1;
    bus.cikis_ready = 1'b1;
    #12;
    chk_quiet("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      p0 = perr_n; f0 = ferr_n; o0 = ovf_n; v0 = val_n;
      if (vecs[i].e_ok != 0) sb.push_back(vecs[i].d);
      send(vecs[i].d, vecs[i].par_ok ? ^vecs[i].d : ~^vecs[i].d, vecs[i].stop);
      chk($sformatf("v%0d_perr", i), perr_n - p0, vecs[i].e_perr);
      chk($sformatf("v%0d_ferr", i), ferr_n - f0, vecs[i].e_ferr);
      chk($sformatf("v%0d_ovf", i), ovf_n - o0, 0);
      chk($sformatf("v%0d_valid_cycles", i), val_n - v0, vecs[i].e_ok);
      chk($sformatf("v%0d_sb_left", i), sb.size(), 0);
      chk($sformatf("v%0d_doluluk", i), int'(bus.doluluk), 0);
    end
    p0 = perr_n; f0 = ferr_n; o0 = ovf_n; v0 = val_n;
    bus.rx = 1'b0;
    @(posedge clk);
    #1 bus.rx = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("glitch_pulses", perr_n + ferr_n + ovf_n - p0 - f0 - o0, 0);
    chk("glitch_valid", val_n - v0, 0);
    sb.push_back(3'b011);
    send(3'b011, 1'b0, 1'b1);
    chk("after_glitch_sb_left", sb.size(), 0);
    bus.cikis_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      o0 = ovf_n;
      if (v <= 4) sb.push_back(3'(v));
      send(3'(v), ^3'(v), 1'b1);
      chk($sformatf("fill%0d_ovf", v), ovf_n - o0, v == 5 ? 1 : 0);
      chk($sformatf("fill%0d_doluluk", v), int'(bus.doluluk), v > 4 ? 4 : v);
    end
    chk("hold_head", int'(bus.gelen_sayi), 1);
    repeat (3) @(posedge clk);
    #1 chk("hold_head_later", int'(bus.gelen_sayi), 1);
    o0 = ovf_n;
    sb.push_back(3'd6);
    fork
      send(3'd6, ^3'd6, 1'b1);
      begin
        repeat (24) @(posedge clk);
        #1 bus.cikis_ready = 1'b1;
        @(posedge clk);
        #1 bus.cikis_ready = 1'b0;
      end
    join
    chk("full_pushpop_ovf", ovf_n - o0, 0);
    chk("full_pushpop_doluluk", int'(bus.doluluk), 4);
    chk("full_pushpop_head", int'(bus.gelen_sayi), 2);
    bus.cikis_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_sb_left", sb.size(), 0);
    chk("drain_doluluk", int'(bus.doluluk), 0);
    chk("drain_valid", int'(bus.cikis_valid), 0);
    bus.cikis_ready = 1'b0;
    sb.push_back(3'd7);
    send(3'd7, 1'b1, 1'b1);
    chk("pre_rst_valid", int'(bus.cikis_valid), 1);
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    #2 rst = 1'b1;
    bus.rx = 1'b1;
    #1 chk_quiet("mid_rst");
    sb.delete();
    p0 = perr_n; f0 = ferr_n; o0 = ovf_n; v0 = val_n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bus.cikis_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("post_rst_pulses", perr_n + ferr_n + ovf_n - p0 - f0 - o0, 0);
    chk("post_rst_valid", val_n - v0, 0);
    sb.push_back(3'b111);
    send(3'b111, 1'b1, 1'b1);
    chk("post_rst_sb_left", sb.size(), 0);
    chk("post_rst_valid_cycles", val_n - v0, 1);
    chk("post_rst_pulses2", perr_n + ferr_n + ovf_n - p0 - f0 - o0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cerceve_alici.md
CERCEVE_ALICI -- requirements
Module: cerceve_alici

Interface
REQ-001 Parameter BIT_CYCLES, default 4: clock cycles per serial bit; legal values are 2 to 255.
REQ-002 Parameter FIFO_DEPTH, default 4: number of received 3-bit words buffered; must be a power of two, 2 to 16.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx  input  1  serial line; idles high; asynchronous to clk.
REQ-006 cikis_ready  input  1  downstream consumer accepts the head word this cycle.
REQ-007 gelen_sayi  output  3  FIFO head word; valid only while cikis_valid=1.
REQ-008 cikis_valid  output  1  FIFO is non-empty.
REQ-009 doluluk  output  $clog2(FIFO_DEPTH)+1  number of words currently buffered.
REQ-010 parity_err  output  1  one-cycle pulse: frame dropped on parity mismatch.
REQ-011 frame_err  output  1  one-cycle pulse: frame dropped because the stop bit sampled 0.
REQ-012 overflow  output  1  one-cycle pulse: good frame dropped because the FIFO was full.

Function
REQ-013 Frame format, in order: start bit 0; data bits d0, d1, d2 (LSB first); even parity bit p = d0^d1^d2; stop bit 1.
REQ-014 rx shall pass through a two-flop synchronizer; both flops reset to 1; all logic below uses only the synchronized value rx_s.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP; a bit counter (0..2) and a cycle counter (0..BIT_CYCLES-1) run alongside.
REQ-016 IDLE -> START on a 1->0 transition of rx_s; the cycle counter is cleared on entry.
REQ-017 START samples rx_s after BIT_CYCLES/2 cycles (integer division); sample=1 means glitch -> IDLE with no pulse; sample=0 -> DATA.
REQ-018 DATA, PARITY and STOP each sample rx_s once, exactly BIT_CYCLES cycles after the previous sample.
REQ-019 DATA stores sample k into bit k; after bit 2 -> PARITY; PARITY -> STOP.
REQ-020 STOP sample, priority order:
- stop=0 -> frame_err.
- else parity mismatch -> parity_err.
- else FIFO full with no pop this cycle -> overflow.
- else push.
In all cases the FSM returns to IDLE in the next cycle.
REQ-021 A falling edge of rx_s is recognised in IDLE only; line activity during START..STOP does not restart the frame.
REQ-022 A pushed word shall appear on gelen_sayi/cikis_valid on the cycle after the STOP sample (latency 1) when the FIFO was empty.
REQ-023 A pop occurs when cikis_valid=1 and cikis_ready=1; the next word, or cikis_valid=0, is shown on the following cycle.
REQ-024 Simultaneous push and pop:
- FIFO full: push is accepted and doluluk is unchanged.
- FIFO empty: no pop occurs; the word is pushed.
REQ-025 gelen_sayi holds its value while cikis_valid=1 and cikis_ready=0.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH.
REQ-027 doluluk saturates at FIFO_DEPTH and never underflows.
REQ-028 Error pulses are mutually exclusive and each lasts exactly one cycle per frame.

Reset
REQ-029 On rst=1, asynchronously and independent of clk:
- FSM = IDLE; all counters = 0; synchronizer flops = 1; FIFO emptied.
- gelen_sayi = 0; cikis_valid = 0; doluluk = 0; parity_err = frame_err = overflow = 0.
REQ-030 Reset asserted mid-frame discards the partial frame; after release the receiver waits in IDLE for a fresh falling edge and generates no pulses.

Structure
REQ-031 Package cerceve_pkg shall hold:
- the FSM state enum;
- frame constants (DATA_BITS=3, START_LVL=0, STOP_LVL=1);
- the even-parity function.
REQ-032 The FIFO shall be one sub-module, kucuk_fifo (parameters WIDTH, DEPTH), with ports clk, rst, push, pop, wdata, rdata, full, empty, count.
REQ-033 Synchronizer, FSM, counters and error logic reside in cerceve_alici.

Verification
REQ-034 BIT_CYCLES=4, send frame for 3'b101 (p=0), cikis_ready=1 -> gelen_sayi=3'b101, cikis_valid pulses 1 cycle, no error pulses.
REQ-035 Send 3'b011 with parity bit 1 -> parity_err single pulse; doluluk stays 0; cikis_valid stays 0.
REQ-036 Send 3'b110 with stop bit 0 -> frame_err pulse; next valid frame 3'b001 is received correctly.
REQ-037 cikis_ready=0, send 5 valid frames 1..5 into FIFO_DEPTH=4:
- overflow on frame 5 only; doluluk=4;
- then cikis_ready=1 drains 1,2,3,4 in order and doluluk returns to 0.
REQ-038 rx low for 1 cycle (glitch) -> no push, no pulse, FSM back in IDLE.
REQ-039 rst asserted after d1 of a frame, released, then 3'b111 sent -> only 3'b111 received; all outputs 0 during reset.
